// File: rtl/sign_narrow_pkg.sv
// Shared widths, occupancy encoding and the fit/narrow helpers for sign_narrow.
// Saturating narrowing is selected with the SIGN_NARROW_SAT_EN macro.
package sign_narrow_pkg;

    localparam int IN_W  = 32;
    localparam int OUT_W = 16;
    localparam int CNT_W = 16;

    localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    // A word fits when every bit from the sign bit down to bit OUT_W-1 agrees.
    function automatic logic fits(input logic [IN_W-1:0] word);
        logic [IN_W-OUT_W:0] top_bits;
        top_bits = word[IN_W-1:OUT_W-1];
        return (top_bits == '0) || (top_bits == '1);
    endfunction

    function automatic logic [OUT_W-1:0] narrow(input logic [IN_W-1:0] word);
`ifdef SIGN_NARROW_SAT_EN
        if (!fits(word)) begin
            return word[IN_W-1] ? OUT_MIN : OUT_MAX;
        end
`endif
        return word[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/sign_narrow_fifo2.sv
// Two-entry registered buffer with valid/ready handshake on both sides.
// ready_o and valid_o decode the occupancy register only.
//
// state | meaning
// EMPTY | no entries, head is stale
// ONE   | head holds the only entry
// FULL  | head and tail both hold entries, upstream stalled
module narrow_fifo2
    import sign_narrow_pkg::*;
#(
    parameter int W = OUT_W + 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o
);

    occ_t         state_q;
    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    logic         push;
    logic         pop;

    assign ready_o = (state_q != FULL);
    assign valid_o = (state_q != EMPTY);
    assign data_o  = head_q;
    assign push    = valid_i && ready_o;
    assign pop     = valid_o && ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        head_q  <= data_i;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    // Simultaneous push and pop: the new word replaces the head directly.
                    if (push && pop) begin
                        head_q <= data_i;
                    end else if (push) begin
                        tail_q  <= data_i;
                        state_q <= FULL;
                    end else if (pop) begin
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_q  <= tail_q;
                        state_q <= ONE;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/sign_narrow.sv
// Narrows 32-bit signed words to 16-bit halfwords, flags non-fitting words and
// counts them. Define SIGN_NARROW_SAT_EN to saturate non-fitting words.
module sign_narrow
    import sign_narrow_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [IN_W-1:0]  data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [OUT_W-1:0] data_o,
    output logic             fit_o,
    input  logic             clr_cnt_i,
    output logic [CNT_W-1:0] ovf_cnt_o
);

    logic             fit_in;
    logic [OUT_W:0]   entry_in;
    logic [OUT_W:0]   entry_out;
    logic             push;

    assign fit_in   = fits(data_i);
    assign entry_in = {fit_in, narrow(data_i)};
    assign push     = valid_i && ready_o;

    narrow_fifo2 #(
        .W(OUT_W + 1)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (entry_in),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (entry_out)
    );

    assign fit_o  = entry_out[OUT_W];
    assign data_o = entry_out[OUT_W-1:0];

    // Counted on the push edge; clear takes priority over a same-cycle increment.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_cnt_o <= '0;
        end else if (clr_cnt_i) begin
            ovf_cnt_o <= '0;
        end else if (push && !fit_in && (ovf_cnt_o != '1)) begin
            ovf_cnt_o <= ovf_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_sign_narrow.sv
// Self-checking bench for sign_narrow: directed cases plus randomized traffic
// compared against a queue-based reference model.
module tb_sign_narrow;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] data_i;
    logic        valid_o;
    logic        ready_i;
    logic [15:0] data_o;
    logic        fit_o;
    logic        clr_cnt_i;
    logic [15:0] ovf_cnt_o;

    int errors = 0;
    int checks = 0;

    logic [16:0] mq[$];
    logic [15:0] cnt_m;

    sign_narrow dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .data_i    (data_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .data_o    (data_o),
        .fit_o     (fit_o),
        .clr_cnt_i (clr_cnt_i),
        .ovf_cnt_o (ovf_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic e_fit(input logic [31:0] w);
        int signed v;
        v = int'(w);
        return (v >= -32768) && (v <= 32767);
    endfunction

    function automatic logic [15:0] e_data(input logic [31:0] w);
        int signed v;
        v = int'(w);
`ifdef SIGN_NARROW_SAT_EN
        if (v > 32767)  return 16'h7FFF;
        if (v < -32768) return 16'h8000;
`endif
        return w[15:0];
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        valid_i = 1'b0; data_i = '0; ready_i = 1'b0; clr_cnt_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mq.delete();
        cnt_m = '0;
    endtask

    // Drives one clock of stimulus and advances the reference model; returns at the next negedge.
    task automatic cycle(input logic v, input logic [31:0] d, input logic r, input logic c,
                         output logic took);
        logic push, pop;
        logic [16:0] tmp;
        valid_i = v; data_i = d; ready_i = r; clr_cnt_i = c;
        push = v && (mq.size() < 2);
        pop  = r && (mq.size() > 0);
        took = push;
        @(posedge clk);
        if (pop) tmp = mq.pop_front();
        if (push) mq.push_back({e_fit(d), e_data(d)});
        if (c) cnt_m = '0;
        else if (push && !e_fit(d) && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
        @(negedge clk);
        valid_i = 1'b0; clr_cnt_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || data_o !== 16'h0 || fit_o !== 1'b0 || ovf_cnt_o !== 16'h0) begin
            errors++;
            $display("FAIL reset: valid=%b ready=%b data=%h fit=%b cnt=%h, want 0 1 0000 0 0000",
                     valid_o, ready_o, data_o, fit_o, ovf_cnt_o);
        end
    endtask

    task automatic test_directed();
        logic t;
        logic [15:0] want;
        do_reset();
        cycle(1'b1, 32'h0000_1234, 1'b1, 1'b0, t);
        checks++;
        if (valid_o !== 1'b1 || data_o !== 16'h1234 || fit_o !== 1'b1 || ovf_cnt_o !== 16'h0) begin
            errors++;
            $display("FAIL dir_1234: valid=%b data=%h fit=%b cnt=%h, want 1 1234 1 0000", valid_o, data_o, fit_o, ovf_cnt_o);
        end
        cycle(1'b1, 32'hFFFF_8000, 1'b1, 1'b0, t);
        checks++;
        if (valid_o !== 1'b1 || data_o !== 16'h8000 || fit_o !== 1'b1 || ovf_cnt_o !== 16'h0) begin
            errors++;
            $display("FAIL dir_neg_min: valid=%b data=%h fit=%b cnt=%h, want 1 8000 1 0000", valid_o, data_o, fit_o, ovf_cnt_o);
        end
        cycle(1'b1, 32'h0000_8000, 1'b1, 1'b0, t);
`ifdef SIGN_NARROW_SAT_EN
        want = 16'h7FFF;
`else
        want = 16'h8000;
`endif
        checks++;
        if (valid_o !== 1'b1 || data_o !== want || fit_o !== 1'b0 || ovf_cnt_o !== 16'h1) begin
            errors++;
            $display("FAIL dir_pos_ovf: valid=%b data=%h fit=%b cnt=%h, want 1 %h 0 0001", valid_o, data_o, fit_o, ovf_cnt_o, want);
        end
        cycle(1'b1, 32'hFFFE_0001, 1'b1, 1'b0, t);
`ifdef SIGN_NARROW_SAT_EN
        want = 16'h8000;
`else
        want = 16'h0001;
`endif
        checks++;
        if (valid_o !== 1'b1 || data_o !== want || fit_o !== 1'b0 || ovf_cnt_o !== 16'h2) begin
            errors++;
            $display("FAIL dir_neg_ovf: valid=%b data=%h fit=%b cnt=%h, want 1 %h 0 0002", valid_o, data_o, fit_o, ovf_cnt_o, want);
        end
        cycle(1'b0, 32'h0, 1'b1, 1'b0, t);
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || ovf_cnt_o !== 16'h2) begin
            errors++;
            $display("FAIL dir_drain: valid=%b ready=%b cnt=%h, want 0 1 0002", valid_o, ready_o, ovf_cnt_o);
        end
    endtask

    task automatic test_back_to_back();
        logic t1, t2, t3, t4, t5;
        logic [15:0] h1, h2, h3;
        do_reset();
        cycle(1'b1, 32'h0000_0011, 1'b0, 1'b0, t1);
        cycle(1'b1, 32'h0000_0022, 1'b0, 1'b0, t2);
        checks++;
        if (ready_o !== 1'b0 || valid_o !== 1'b1 || data_o !== 16'h0011) begin
            errors++;
            $display("FAIL bp_full: ready=%b valid=%b data=%h, want 0 1 0011", ready_o, valid_o, data_o);
        end
        cycle(1'b1, 32'h0000_0033, 1'b0, 1'b0, t3);
        checks++;
        if (t3 !== 1'b0 || ready_o !== 1'b0 || data_o !== 16'h0011) begin
            errors++;
            $display("FAIL bp_hold: ready=%b data=%h, want 0 0011", ready_o, data_o);
        end
        h1 = data_o;
        cycle(1'b1, 32'h0000_0033, 1'b1, 1'b0, t4);
        h2 = data_o;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b1 || h2 !== 16'h0022) begin
            errors++;
            $display("FAIL bp_pop1: ready=%b valid=%b data=%h, want 1 1 0022", ready_o, valid_o, h2);
        end
        cycle(1'b1, 32'h0000_0033, 1'b1, 1'b0, t5);
        h3 = data_o;
        checks++;
        if (h1 !== 16'h0011 || h3 !== 16'h0033 || t5 !== 1'b1 || valid_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_order: got %h %h %h valid=%b, want 0011 0022 0033 1", h1, h2, h3, valid_o);
        end
        cycle(1'b0, 32'h0, 1'b1, 1'b0, t1);
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: valid=%b, want 0", valid_o);
        end
    endtask

    task automatic test_counter();
        logic t;
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h0001_0000 + 32'(i), 1'b1, 1'b0, t);
        checks++;
        if (ovf_cnt_o !== 16'd5) begin
            errors++;
            $display("FAIL cnt_five: cnt=%h, want 0005", ovf_cnt_o);
        end
        cycle(1'b1, 32'h8000_0000, 1'b1, 1'b1, t);
        checks++;
        if (ovf_cnt_o !== 16'd0 || fit_o !== 1'b0) begin
            errors++;
            $display("FAIL cnt_clr_wins: cnt=%h fit=%b, want 0000 0", ovf_cnt_o, fit_o);
        end
        for (int i = 0; i < 65535; i++) cycle(1'b1, 32'h7000_0000, 1'b1, 1'b0, t);
        checks++;
        if (ovf_cnt_o !== 16'hFFFF) begin
            errors++;
            $display("FAIL cnt_preload: cnt=%h, want ffff", ovf_cnt_o);
        end
        cycle(1'b1, 32'hC000_0000, 1'b1, 1'b0, t);
        checks++;
        if (ovf_cnt_o !== 16'hFFFF) begin
            errors++;
            $display("FAIL cnt_sat: cnt=%h, want ffff", ovf_cnt_o);
        end
        cycle(1'b0, 32'h0, 1'b1, 1'b1, t);
        checks++;
        if (ovf_cnt_o !== 16'h0) begin
            errors++;
            $display("FAIL cnt_clr_idle: cnt=%h, want 0000", ovf_cnt_o);
        end
    endtask

    task automatic test_random();
        logic        pend, v, t, r, c;
        logic [31:0] w;
        logic [31:0] edges[6] = '{32'h0000_7FFF, 32'h0000_8000, 32'hFFFF_8000,
                                  32'hFFFF_7FFF, 32'h7FFF_FFFF, 32'h8000_0000};
        logic [16:0] nb;
        do_reset();
        pend = 1'b0;
        w = '0;
        for (int n = 0; n < 400; n++) begin
            if (!pend) begin
                v = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 3))
                    0: w = $urandom;
                    1: begin nb = 17'($urandom); w = {{16{nb[15]}}, nb[15:0]}; end
                    2: w = edges[$urandom_range(0, 5)];
                    default: begin nb = 17'($urandom); w = {{15{nb[16]}}, nb}; end
                endcase
            end else begin
                v = 1'b1;
            end
            r = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 19) == 0);
            cycle(v, w, r, c, t);
            pend = v && !t;
            checks++;
            if (ready_o !== (mq.size() < 2) || valid_o !== (mq.size() > 0) || ovf_cnt_o !== cnt_m) begin
                errors++;
                $display("FAIL rnd_ctrl[%0d]: ready=%b valid=%b cnt=%h, want %b %b %h",
                         n, ready_o, valid_o, ovf_cnt_o, mq.size() < 2, mq.size() > 0, cnt_m);
            end
            if (mq.size() > 0) begin
                checks++;
                if ({fit_o, data_o} !== mq[0]) begin
                    errors++;
                    $display("FAIL rnd_head[%0d]: fit=%b data=%h, want fit=%b data=%h",
                             n, fit_o, data_o, mq[0][16], mq[0][15:0]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic t;
        do_reset();
        cycle(1'b1, 32'h0002_0000, 1'b0, 1'b0, t);
        cycle(1'b1, 32'h0000_0055, 1'b0, 1'b0, t);
        valid_i = 1'b1; data_i = 32'h0000_0066;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || data_o !== 16'h0 || fit_o !== 1'b0 || ovf_cnt_o !== 16'h0) begin
            errors++;
            $display("FAIL async_rst: valid=%b ready=%b data=%h fit=%b cnt=%h, want 0 1 0000 0 0000",
                     valid_o, ready_o, data_o, fit_o, ovf_cnt_o);
        end
        valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        cnt_m = '0;
        cycle(1'b0, 32'h0, 1'b1, 1'b0, t);
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL async_rst_after: valid=%b ready=%b, want 0 1", valid_o, ready_o);
        end
    endtask

    initial begin
        rst = 1'b1;
        valid_i = 1'b0; data_i = '0; ready_i = 1'b0; clr_cnt_i = 1'b0;
        cnt_m = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_counter();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
